bus_mailbox_responder: RTL and testbench

- Module-side responder for the pulsed, clock-crossed CPU bus.
- Sits in a peripheral clock domain and decodes a 4-register window.
- Buffers CPU writes into a TX FIFO that local logic drains.
- Buffers local data into an RX FIFO that the CPU reads, returning read data exactly one clock after each bus pulse, as the crossing bridge requires.

---
 rtl/cpu_reg_package.sv | 39 +++
 rtl/bus_mailbox_responder_sync_fifo.sv | 59 +++++
 rtl/bus_mailbox_responder.sv | 126 ++++++++++++
 tb/tb_bus_mailbox_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_reg_package.sv
// Shared CPU-bus register definitions: bus widths, mailbox register offsets,
// control/status bit positions and the packed STATUS word layout.
package cpu_reg_package;

  localparam int address_width = 32;
  localparam int data_width    = 32;

  localparam int MBOX_TXDATA_OFS  = 0;
  localparam int MBOX_RXDATA_OFS  = 4;
  localparam int MBOX_STATUS_OFS  = 8;
  localparam int MBOX_CONTROL_OFS = 12;

  localparam int STATUS_TX_FULL_BIT      = 0;
  localparam int STATUS_TX_EMPTY_BIT     = 1;
  localparam int STATUS_RX_FULL_BIT      = 2;
  localparam int STATUS_RX_EMPTY_BIT     = 3;
  localparam int STATUS_TX_OVERFLOW_BIT  = 4;
  localparam int STATUS_RX_UNDERFLOW_BIT = 5;
  localparam int STATUS_RX_COUNT_LSB     = 8;
  localparam int STATUS_TX_COUNT_LSB     = 16;

  localparam int CONTROL_CLEAR_BIT  = 0;
  localparam int CONTROL_FLUSH_BIT  = 1;
  localparam int CONTROL_IRQ_EN_BIT = 2;

  typedef struct packed {
    logic [7:0] reserved;
    logic [7:0] tx_count;
    logic [7:0] rx_count;
    logic [1:0] pad;
    logic       rx_underflow;
    logic       tx_overflow;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_empty;
    logic       tx_full;
  } mbox_status_t;

endpackage

// File: rtl/bus_mailbox_responder_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Flush beats push/pop; a push
// when full or a pop when empty is silently dropped.
module sync_fifo #(
  parameter int DataWidth = 32,
  parameter int Depth     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DataWidth-1:0]       push_data_i,
  input  logic                       pop_i,
  output logic [DataWidth-1:0]       pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int AW = $clog2(Depth);

  if (Depth < 2 || Depth > 128 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: Depth must be a power of two in 2..128");
  end

  logic [DataWidth-1:0] mem [Depth];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty_o = (wptr == rptr);
  assign count_o = wptr - rptr;

  assign do_push = push_i && !full_o  && !flush_i;
  assign do_pop  = pop_i  && !empty_o && !flush_i;

  // Head is forced to zero when empty so the output never shows stale data.
  assign pop_data_o = empty_o ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; contents are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/bus_mailbox_responder.sv
// Peripheral-side mailbox on the pulsed CPU bus: TX FIFO written by the CPU,
// RX FIFO read by the CPU, STATUS/CONTROL registers and an RX interrupt.
module bus_mailbox_responder
  import cpu_reg_package::*;
#(
  parameter logic [31:0] BaseAddress = 32'h0000_9000,
  parameter int          AddrWidth   = address_width,
  parameter int          DataWidth   = data_width,
  parameter int          Depth       = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [AddrWidth-1:0] address_i,
  input  logic                 we_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic [DataWidth-1:0] tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  input  logic [DataWidth-1:0] rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic                 irq_o
);

  localparam int CW = $clog2(Depth) + 1;

  if (BaseAddress == 32'h0) begin : g_bad_base
    $error("bus_mailbox_responder: BaseAddress must be nonzero (idle bus drives 0)");
  end

  logic [AddrWidth-1:0] ofs;
  logic                 hit;
  logic [3:0]           reg_ofs;
  logic                 tx_push, tx_pop, rx_push, rx_pop;
  logic                 ctrl_write, flush, clear;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]        tx_count, rx_count;
  logic [DataWidth-1:0] rx_head;
  logic                 tx_overflow, rx_underflow, rx_irq_en;
  mbox_status_t         status;

  // Addresses below the base wrap to large offsets and therefore miss.
  assign ofs     = address_i - BaseAddress[AddrWidth-1:0];
  assign hit     = (ofs < AddrWidth'(16)) && (ofs[1:0] == 2'b00);
  assign reg_ofs = ofs[3:0];

  assign ctrl_write = hit && we_i && (reg_ofs == 4'(MBOX_CONTROL_OFS));
  assign flush      = ctrl_write && data_i[CONTROL_FLUSH_BIT];
  assign clear      = ctrl_write && data_i[CONTROL_CLEAR_BIT];

  assign tx_push = hit && we_i  && (reg_ofs == 4'(MBOX_TXDATA_OFS));
  assign rx_pop  = hit && !we_i && (reg_ofs == 4'(MBOX_RXDATA_OFS));
  assign tx_pop  = tx_valid_o && tx_ready_i;
  assign rx_push = rx_valid_i && rx_ready_o;

  assign tx_valid_o = !tx_empty;
  assign rx_ready_o = !rx_full;

  sync_fifo #(.DataWidth(DataWidth), .Depth(Depth)) u_tx_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush),
    .push_i      (tx_push),
    .push_data_i (data_i),
    .pop_i       (tx_pop),
    .pop_data_o  (tx_data_o),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_count)
  );

  sync_fifo #(.DataWidth(DataWidth), .Depth(Depth)) u_rx_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush),
    .push_i      (rx_push),
    .push_data_i (rx_data_i),
    .pop_i       (rx_pop),
    .pop_data_o  (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .count_o     (rx_count)
  );

  always_comb begin
    status              = '0;
    status.tx_full      = tx_full;
    status.tx_empty     = tx_empty;
    status.rx_full      = rx_full;
    status.rx_empty     = rx_empty;
    status.tx_overflow  = tx_overflow;
    status.rx_underflow = rx_underflow;
    status.rx_count     = 8'(rx_count);
    status.tx_count     = 8'(tx_count);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, which is what makes STATUS show the old state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o       <= '0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      rx_irq_en    <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      // A new event in the same cycle as a clear leaves the flag set.
      tx_overflow  <= (tx_overflow  && !clear) || (tx_push && tx_full);
      rx_underflow <= (rx_underflow && !clear) || (rx_pop && rx_empty);
      irq_o        <= rx_irq_en && !rx_empty;

      if (ctrl_write) rx_irq_en <= data_i[CONTROL_IRQ_EN_BIT];

      if (hit && !we_i) begin
        unique case (reg_ofs)
          4'(MBOX_RXDATA_OFS):  data_o <= rx_head;
          4'(MBOX_STATUS_OFS):  data_o <= DataWidth'(status);
          4'(MBOX_CONTROL_OFS): data_o <= DataWidth'({rx_irq_en, 2'b00});
          default:              data_o <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_mailbox_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a queue-based model of the mailbox.
module tb_bus_mailbox_responder;

  localparam logic [31:0] BASE  = 32'h0000_9000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address, data, rx_data;
  logic        we, tx_ready, rx_valid;
  logic [31:0] data_out, tx_data;
  logic        tx_valid, rx_ready, irq;

  always #5 clk = ~clk;

  bus_mailbox_responder #(.BaseAddress(BASE), .Depth(DEPTH)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .address_i  (address),
    .we_i       (we),
    .data_i     (data),
    .data_o     (data_out),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .irq_o      (irq)
  );

  int passed = 0;
  int total  = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          m_ovf, m_unf, m_irq_en, m_irq;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 0; m_unf = 0; m_irq_en = 0; m_irq = 0;
    m_data = '0;
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0]     = (tx_q.size() == DEPTH);
    s[1]     = (tx_q.size() == 0);
    s[2]     = (rx_q.size() == DEPTH);
    s[3]     = (rx_q.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_unf;
    s[15:8]  = 8'(rx_q.size());
    s[23:16] = 8'(tx_q.size());
    return s;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit          hit, tx_full_pre, rx_empty_pre, rx_has_room, tx_pop, rx_push;
    int          r;
    logic [31:0] head;
    hit = (address >= BASE) && (address <= BASE + 12) && (address[1:0] == 2'b00);
    r   = int'((address - BASE) >> 2);
    tx_full_pre  = (tx_q.size() == DEPTH);
    rx_empty_pre = (rx_q.size() == 0);
    rx_has_room  = (rx_q.size() < DEPTH);
    tx_pop  = (tx_q.size() != 0) && tx_ready;
    rx_push = rx_valid && rx_has_room;
    m_irq   = m_irq_en && !rx_empty_pre;
    head    = rx_empty_pre ? 32'h0 : rx_q[0];

    if (hit && !we) begin
      case (r)
        1:       m_data = head;
        2:       m_data = model_status();
        3:       m_data = {29'h0, m_irq_en, 2'b00};
        default: m_data = 32'h0;
      endcase
    end

    if (hit && we && r == 3) begin
      if (data[0]) begin m_ovf = 0; m_unf = 0; end
      m_irq_en = data[2];
    end

    if (hit && we && r == 3 && data[1]) begin
      tx_q.delete();
      rx_q.delete();
    end else begin
      if (tx_pop) void'(tx_q.pop_front());
      if (hit && we && r == 0) begin
        if (tx_full_pre) m_ovf = 1;
        else             tx_q.push_back(data);
      end
      if (hit && !we && r == 1) begin
        if (rx_empty_pre) m_unf = 1;
        else              void'(rx_q.pop_front());
      end
      if (rx_push) rx_q.push_back(rx_data);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("data_o",     data_out, m_data);
    check("tx_valid_o", 32'(tx_valid), 32'(tx_q.size() != 0));
    check("tx_data_o",  tx_data, (tx_q.size() != 0) ? tx_q[0] : 32'h0);
    check("rx_ready_o", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
    check("irq_o",      32'(irq), 32'(m_irq));
  endtask

  task automatic bus(input logic [31:0] a, input bit w, input logic [31:0] d);
    address = a; we = w; data = d;
    cycle();
    address = '0; we = 1'b0; data = '0;
    cycle();
  endtask

  initial begin
    reset_n = 1'b0;
    address = '0; we = 1'b0; data = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    model_reset();
    #3;
    check("reset_data_o",   data_out, 32'h0);
    check("reset_rx_ready", 32'(rx_ready), 32'h1);
    check("reset_irq",      32'(irq), 32'h0);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    bus(BASE + 8, 0, 0);
    check("status_after_reset", data_out, 32'h0000_000A);

    bus(BASE, 1, 32'hDEAD_BEEF);
    bus(BASE, 1, 32'h1234_5678);
    check("tx_head_first", tx_data, 32'hDEAD_BEEF);
    check("tx_valid_two",  32'(tx_valid), 32'h1);
    tx_ready = 1'b1; cycle(); tx_ready = 1'b0;
    check("tx_head_second", tx_data, 32'h1234_5678);
    tx_ready = 1'b1; cycle(); tx_ready = 1'b0;
    check("tx_valid_drained", 32'(tx_valid), 32'h0);

    for (int i = 0; i < 17; i++) bus(BASE, 1, 32'h100 + 32'(i));
    bus(BASE + 8, 0, 0);
    check("status_tx_overflow", data_out, 32'h0010_0019);
    check("tx_head_after_fill", tx_data, 32'h0000_0100);
    bus(BASE + 12, 1, 32'h1);
    bus(BASE + 8, 0, 0);
    check("status_overflow_cleared", data_out, 32'h0010_0009);
    bus(BASE + 12, 1, 32'h2);
    bus(BASE + 8, 0, 0);
    check("status_after_flush", data_out, 32'h0000_000A);

    bus(BASE + 12, 1, 32'h4);
    bus(BASE + 12, 0, 0);
    check("control_readback", data_out, 32'h0000_0004);
    rx_valid = 1'b1; rx_data = 32'hA5; cycle(); rx_valid = 1'b0;
    check("irq_one_cycle_after_push", 32'(irq), 32'h0);
    cycle();
    check("irq_two_cycles_after_push", 32'(irq), 32'h1);
    bus(BASE + 4, 0, 0);
    check("rx_read_a5", data_out, 32'h0000_00A5);
    check("irq_dropped", 32'(irq), 32'h0);
    bus(BASE + 4, 0, 0);
    check("rx_read_empty", data_out, 32'h0);
    bus(BASE + 8, 0, 0);
    check("status_underflow", data_out, 32'h0000_002A);
    bus(BASE + 12, 1, 32'h5);

    address = BASE + 4; we = 1'b0; rx_valid = 1'b1; rx_data = 32'h55;
    cycle();
    address = '0; rx_valid = 1'b0;
    cycle();
    check("rx_read_empty_with_push", data_out, 32'h0);
    bus(BASE + 8, 0, 0);
    check("status_underflow_count1", data_out, 32'h0000_0122);
    bus(BASE + 4, 0, 0);
    check("rx_read_55", data_out, 32'h0000_0055);

    bus(BASE - 4, 1, 32'hFFFF_FFFF);
    bus(BASE + 16, 1, 32'hFFFF_FFFF);
    bus(BASE + 2, 0, 0);
    check("miss_keeps_data", data_out, 32'h0000_0055);

    for (int i = 0; i < 1500; i++) begin
      int op;
      bit rx_heavy;
      rx_heavy = (i / 250) % 2 == 0;
      tx_ready = rx_heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid = rx_heavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rx_data  = $urandom;
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2: begin address = BASE;     we = 1'b1; data = $urandom; end
        3, 4:    begin address = BASE + 4; we = 1'b0; data = $urandom; end
        5:       begin address = BASE + 8; we = 1'b0; data = '0; end
        6:       begin address = BASE + 12; we = 1'b1;
                       data = ($urandom_range(0, 7) == 0) ? 32'h2 : ($urandom & 32'h5); end
        7:       begin address = BASE + 12; we = 1'b0; data = '0; end
        8:       begin address = BASE + 32'($urandom_range(0, 1)) * 4; we = ~we; data = $urandom; end
        9:       begin address = BASE + 32'h10 + 32'($urandom_range(0, 3)) * 4; we = 1'b1; data = $urandom; end
        default: begin address = '0; we = 1'b0; data = '0; end
      endcase
      cycle();
      address = '0; we = 1'b0; data = '0;
    end
    tx_ready = 1'b0; rx_valid = 1'b0;
    cycle();

    bus(BASE + 12, 1, 32'h7);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 32'hC0 + 32'(i); cycle();
    end
    rx_valid = 1'b0;
    bus(BASE + 8, 0, 0);
    check("status_rx_three", data_out, 32'h0000_0302);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_rx_ready", 32'(rx_ready), 32'h1);
    check("async_reset_irq",      32'(irq), 32'h0);
    check("async_reset_data_o",   data_out, 32'h0);
    check("async_reset_tx_valid", 32'(tx_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus(BASE + 8, 0, 0);
    check("status_after_async_reset", data_out, 32'h0000_000A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
